// File: rtl/octave_ctrl_pkg.sv
// Range encoding and the saturating octave step shared by the range
// indicator blocks. The value 2'b00 is never produced.
package octave_ctrl_pkg;

  typedef enum logic [1:0] {
    RANGE_LO = 2'b01,
    RANGE_MI = 2'b10,
    RANGE_HI = 2'b11
  } range_e;

  // One octave per press, saturating at both ends; simultaneous presses cancel.
  function automatic range_e range_step(input range_e cur, input logic up, input logic dn);
    range_e nxt;
    nxt = cur;
    if (up && !dn) begin
      case (cur)
        RANGE_LO: nxt = RANGE_MI;
        RANGE_MI: nxt = RANGE_HI;
        RANGE_HI: nxt = RANGE_HI;
        default:  nxt = RANGE_MI;
      endcase
    end else if (dn && !up) begin
      case (cur)
        RANGE_HI: nxt = RANGE_MI;
        RANGE_MI: nxt = RANGE_LO;
        RANGE_LO: nxt = RANGE_LO;
        default:  nxt = RANGE_MI;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/octave_ctrl_debounce.sv
// Per-button front end: two-flop synchronizer, stable-count debounce filter
// and a registered rising-edge press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 2_000_000,
  parameter int CNT_W      = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any sample that agrees with the accepted level restarts the count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/octave_ctrl.sv
// Octave range controller: debounced up/down buttons step a saturating
// LO/MI/HI range, with a one-cycle pulse whenever the range moves.
module octave_ctrl
  import octave_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 2_000_000,
  parameter int CNT_W      = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] state,
  output logic       changed
);

  logic   w_up_press;
  logic   w_dn_press;
  range_e w_next;
  range_e r_state;
  logic   r_changed;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up),
    .press   (w_up_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_dn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_down),
    .press   (w_dn_press)
  );

  // Presses arriving while disabled fall through here and are lost.
  always_comb begin
    w_next = r_state;
    if (en) w_next = range_step(r_state, w_up_press, w_dn_press);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RANGE_MI;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_changed <= (w_next != r_state);
    end
  end

  assign state   = r_state;
  assign changed = r_changed;

endmodule
